sad_search_ctrl: RTL
====================

Name: sad_search_ctrl

Overview:
- Host-side requester for the SAD engine's control handshake. It drives init and ack, and observes done and the SAD result.
- It sweeps N_CAND candidate block positions, running one SAD computation per candidate, and tracks the minimum SAD and its index.
- It sits between the motion-estimation top level and the SAD engine. It reports the best candidate through a valid/ack result handshake.

Parameters:
- N_CAND, 16, number of candidates per search (at least 1).
- IDX_W, 4, width of the candidate index; 2^IDX_W must be at least N_CAND.
- SAD_W, 16, width of the SAD result.
- TIMEOUT, 255, maximum cycles to wait for done (used only with SAD_TIMEOUT_EN).

Ports:
- clk, input, 1, single clock; all logic on the rising edge.
- rst, input, 1, synchronous active-low reset.
- start, input, 1, begin a search; sampled only in IDLE.
- init, output, 1, one-cycle pulse to the SAD engine to start one computation.
- ack, output, 1, one-cycle pulse acknowledging the engine's done.
- done, input, 1, SAD engine result ready; held high until ack.
- sad_in, input, SAD_W, SAD engine result; valid while done=1.
- cand_idx, output, IDX_W, current candidate index; drives the engine's address generator.
- busy, output, 1, high in any state other than IDLE.
- res_valid, output, 1, search result available.
- res_ack, input, 1, consumer accepts the result.
- best_sad, output, SAD_W, minimum SAD of the last search.
- best_idx, output, IDX_W, index of that minimum.
- err, output, 1, timeout occurred during this search (constant 0 without SAD_TIMEOUT_EN).

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE.
  - Outputs: init=0, ack=0, busy=0, res_valid=0, err=0, cand_idx=0, best_idx=0, best_sad=all ones.
  - Reset mid-search abandons the search. The engine is not acked; the system resets it with the same reset.
- All outputs are registered. There is no combinational path from any input to any output.
- States:
  - IDLE: if start=1, clear cand_idx to 0, best_sad to all ones, best_idx to 0 and err to 0, then go to REQ.
  - REQ: init=1 for exactly one cycle, then go to WAIT.
  - WAIT: hold until done=1.
    - On the cycle done=1 is sampled, compare sad_in with best_sad.
    - If sad_in < best_sad (unsigned, strict), load best_sad=sad_in and best_idx=cand_idx.
    - Then go to ACK.
  - ACK: ack=1 for exactly one cycle. The engine leaves its DONE state on this edge, so done is low from the next cycle.
    - Then go to NEXT.
  - NEXT: done must be 0 here; if done is still 1, stay in NEXT and do not re-acknowledge.
    - If cand_idx == N_CAND-1, go to REPORT.
    - Otherwise increment cand_idx and go to REQ.
  - REPORT: res_valid=1, holding best_sad, best_idx and err stable.
    - On res_ack=1, clear res_valid and go to IDLE.
- Tie rule: equal SAD never replaces the stored best, so the lowest index wins.
- start is ignored while busy=1 and while in REPORT. A start asserted in the same cycle as res_ack is ignored; it must be seen again in IDLE.
- Per-candidate overhead: 4 cycles (REQ, ACK, NEXT and the done-sampling cycle), plus the engine's compute time.
- cand_idx is stable from REQ through NEXT of each candidate.
- With N_CAND=1, exactly one init/ack pair is issued.
- No wrap-around: cand_idx never exceeds N_CAND-1.

Optional Feature:
- Macro: SAD_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in WAIT.
  - If done is still 0 after TIMEOUT cycles, set err=1 (sticky until the next start) and skip the candidate: best is not updated, ack is not issued, and the FSM goes to NEXT.
  - The counter clears on entry to WAIT.
- When undefined: WAIT waits indefinitely, err is tied to 0, and no counter logic exists.

Test Plan:
- Reset, then IDLE with start=0 for 10 cycles -> init=0, ack=0, busy=0, res_valid=0, best_sad=16'hFFFF, cand_idx=0.
- Search with N_CAND=4, engine model returning SADs 40, 25, 30, 60 after 5 cycles each -> 4 single-cycle init pulses and 4 single-cycle acks, cand_idx 0..3, then res_valid=1, best_sad=25, best_idx=1.
- Tie case with SADs 10, 10, 7, 7 -> best_sad=7, best_idx=2.
- Hold res_ack=0 for 20 cycles with start pulsed during REPORT -> outputs stable, no new init; res_ack=1 -> IDLE next cycle; a new start then begins at cand_idx=0.
- Assert rst=0 during WAIT of candidate 2 -> the next cycle shows all reset values and no ack pulse is emitted.
- SAD_TIMEOUT_EN defined, TIMEOUT=8, engine never asserts done for candidate 1 of 3 (SADs 50, -, 20) -> err=1, no ack for candidate 1, result best_sad=20, best_idx=2.

Source files
------------

// File: rtl/sad_search_ctrl.sv
// Sweeps N_CAND candidate positions through the SAD engine and keeps the lowest SAD and its index.
// Optional feature macro: SAD_TIMEOUT_EN (per-candidate done timeout with sticky err).
module sad_search_ctrl #(
    parameter int N_CAND  = 16,
    parameter int IDX_W   = 4,
    parameter int SAD_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    output logic             init_o,
    output logic             ack_o,
    input  logic             done_i,
    input  logic [SAD_W-1:0] sad_in_i,
    output logic [IDX_W-1:0] cand_idx_o,
    output logic             busy_o,
    output logic             res_valid_o,
    input  logic             res_ack_i,
    output logic [SAD_W-1:0] best_sad_o,
    output logic [IDX_W-1:0] best_idx_o,
    output logic             err_o,
    output logic [2:0]       state_o
);

    // Handshakes: init_o and ack_o are single-cycle pulses toward the engine, which holds
    // done_i until it sees ack_o; res_valid_o holds until the cycle res_ack_i is sampled high.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_ACK    = 3'd3,
        S_NEXT   = 3'd4,
        S_REPORT = 3'd5
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CAND - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cand_q, cand_d;
    logic [SAD_W-1:0]   best_sad_q, best_sad_d;
    logic [IDX_W-1:0]   best_idx_q, best_idx_d;
    logic               init_q, init_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               res_valid_q, res_valid_d;

`ifdef SAD_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        best_sad_d = best_sad_q;
        best_idx_d = best_idx_q;
`ifdef SAD_TIMEOUT_EN
        err_d      = err_q;
        tmo_cnt_d  = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cand_d     = '0;
                    best_sad_d = '1;
                    best_idx_d = '0;
`ifdef SAD_TIMEOUT_EN
                    err_d      = 1'b0;
`endif
                    state_d    = S_REQ;
                end
            end
            S_REQ: state_d = S_WAIT;
            S_WAIT: begin
                if (done_i) begin
                    // Strict compare: a tie keeps the earlier (lower) index.
                    if (sad_in_i < best_sad_q) begin
                        best_sad_d = sad_in_i;
                        best_idx_d = cand_q;
                    end
                    state_d = S_ACK;
                end
`ifdef SAD_TIMEOUT_EN
                else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_NEXT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
`endif
            end
            S_ACK: state_d = S_NEXT;
            S_NEXT: begin
                // A lingering done means the engine has not yet left DONE; wait without re-acking.
                if (!done_i) begin
                    if (cand_q == LAST_IDX) begin
                        state_d = S_REPORT;
                    end else begin
                        cand_d  = cand_q + IDX_W'(1);
                        state_d = S_REQ;
                    end
                end
            end
            S_REPORT: begin
                if (res_ack_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        init_d      = (state_d == S_REQ);
        ack_d       = (state_d == S_ACK);
        busy_d      = (state_d != S_IDLE);
        res_valid_d = (state_d == S_REPORT);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            cand_q      <= '0;
            best_sad_q  <= '1;
            best_idx_q  <= '0;
            init_q      <= 1'b0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            best_sad_q  <= best_sad_d;
            best_idx_q  <= best_idx_d;
            init_q      <= init_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
        end
    end

`ifdef SAD_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign init_o      = init_q;
    assign ack_o       = ack_q;
    assign busy_o      = busy_q;
    assign res_valid_o = res_valid_q;
    assign cand_idx_o  = cand_q;
    assign best_sad_o  = best_sad_q;
    assign best_idx_o  = best_idx_q;
    assign state_o     = state_q;

endmodule
